// File: rtl/arm_dp_pkg.sv
// Shared encodings for the ARM data-processing unit: opcodes, shift types,
// NZCV bit positions and the control-state enum.
package arm_dp_pkg;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_HOLD    = 2'd2
    } dp_state_t;

endpackage

// File: rtl/dp_barrel_shifter.sv
// Combinational operand-2 shifter: LSL/LSR/ASR/ROR with ARM carry-out rules,
// including the amount-0 cases (pass-through with c_in, ROR #0 = RRX).
module dp_barrel_shifter
    import arm_dp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [1:0]       sh_type,
    input  logic [SHW-1:0]   amt,
    input  logic             c_in,
    output logic [WIDTH-1:0] shifted,
    output logic             carry
);

    logic [WIDTH:0]        lsl_w;
    logic [WIDTH:0]        lsr_w;
    logic signed [WIDTH:0] asr_in;
    logic signed [WIDTH:0] asr_out;
    logic [WIDTH-1:0]      ror_w;

    // The extra bit on each side catches the last bit shifted out.
    always_comb begin
        lsl_w   = {1'b0, value} << amt;
        lsr_w   = {value, 1'b0} >> amt;
        asr_in  = {value, 1'b0};
        asr_out = asr_in >>> amt;
        ror_w   = (value >> amt) | (value << (WIDTH - int'(amt)));

        shifted = value;
        carry   = c_in;
        if (amt == '0) begin
            if (sh_type == SH_ROR) begin
                shifted = {c_in, value[WIDTH-1:1]};
                carry   = value[0];
            end
        end else begin
            unique case (sh_type)
                SH_LSL: begin
                    shifted = lsl_w[WIDTH-1:0];
                    carry   = lsl_w[WIDTH];
                end
                SH_LSR: begin
                    shifted = lsr_w[WIDTH:1];
                    carry   = lsr_w[0];
                end
                SH_ASR: begin
                    shifted = asr_out[WIDTH:1];
                    carry   = asr_out[0];
                end
                default: begin
                    shifted = ror_w;
                    carry   = ror_w[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/arm_dp_unit.sv
// Registered ARM data-processing unit: operand-2 shifter, 16 DP opcodes,
// NZCV register, valid/ready on both sides and an optional shift-add MUL/MLA.
module arm_dp_unit
    import arm_dp_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic             s_bit,
    input  logic             mul,
    input  logic             acc,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    input  logic [1:0]       shift_type,
    input  logic [SHW-1:0]   shift_amt,
    input  logic             flags_load,
    input  logic [3:0]       flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             wr_en,
    output logic [3:0]       flags
);

    localparam logic MUL_ON = (MUL_EN != 0);

    function automatic logic add_ovf(input logic signed [WIDTH-1:0] x,
                                     input logic signed [WIDTH-1:0] y,
                                     input logic signed [WIDTH-1:0] s);
        return (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    endfunction

    function automatic logic [3:0] pack_nzcv(input logic [WIDTH-1:0] res,
                                             input logic c, input logic v);
        return {res[WIDTH-1], (res == '0), c, v};
    endfunction

    dp_state_t        state;
    logic             vld_p1;
    logic [WIDTH-1:0] result_p1;
    logic             wr_en_p1;
    logic [3:0]       flags_q;
    logic [3:0]       flags_nxt;
    logic             mul_s;

    logic             accept;
    logic             mul_eff;
    logic             mul_start;
    logic             mul_run;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             alu_acc;

    logic [WIDTH-1:0] op2;
    logic             sh_c;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_ci;
    logic [WIDTH:0]   sum;
    logic             is_arith;
    logic             is_test;
    logic [WIDTH-1:0] logic_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             alu_setf;

    assign in_ready  = (state == ST_IDLE) && (!vld_p1 || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_eff   = mul && MUL_ON;
    assign mul_start = accept && mul_eff;
    assign alu_acc   = accept && !mul_eff;
    assign mul_run   = (state == ST_MUL_RUN);

    assign out_valid = vld_p1;
    assign result    = result_p1;
    assign wr_en     = wr_en_p1;
    assign flags     = flags_q;

    // ---- stage p0: operand-2 shift and ALU evaluation
    dp_barrel_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .value   (op_b),
        .sh_type (shift_type),
        .amt     (shift_amt),
        .c_in    (flags_q[FLAG_C]),
        .shifted (op2),
        .carry   (sh_c)
    );

    always_comb begin
        add_x    = op_a;
        add_y    = op2;
        add_ci   = 1'b0;
        is_arith = 1'b1;
        case (opcode)
            OP_SUB, OP_CMP: begin
                add_y  = ~op2;
                add_ci = 1'b1;
            end
            OP_RSB: begin
                add_x  = op2;
                add_y  = ~op_a;
                add_ci = 1'b1;
            end
            OP_ADC: add_ci = flags_q[FLAG_C];
            OP_SBC: begin
                add_y  = ~op2;
                add_ci = flags_q[FLAG_C];
            end
            OP_RSC: begin
                add_x  = op2;
                add_y  = ~op_a;
                add_ci = flags_q[FLAG_C];
            end
            OP_ADD, OP_CMN: add_ci = 1'b0;
            default: is_arith = 1'b0;
        endcase

        case (opcode)
            OP_AND, OP_TST: logic_res = op_a & op2;
            OP_EOR, OP_TEQ: logic_res = op_a ^ op2;
            OP_ORR:         logic_res = op_a | op2;
            OP_MOV:         logic_res = op2;
            OP_BIC:         logic_res = op_a & ~op2;
            OP_MVN:         logic_res = ~op2;
            default:        logic_res = '0;
        endcase

        sum      = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_ci};
        alu_res  = is_arith ? sum[WIDTH-1:0] : logic_res;
        alu_c    = is_arith ? sum[WIDTH] : sh_c;
        alu_v    = is_arith ? add_ovf(add_x, add_y, sum[WIDTH-1:0]) : flags_q[FLAG_V];
        is_test  = (opcode[3:2] == 2'b10);
        alu_setf = s_bit || is_test;
    end

    // A flag-setting accept beats an MSR load; a finishing MULS then
    // overwrites only N and Z on top of whatever the load wrote.
    always_comb begin
        flags_nxt = flags_q;
        if (flags_load) flags_nxt = flags_in;
        if (alu_acc && alu_setf) flags_nxt = pack_nzcv(alu_res, alu_c, alu_v);
        if (mul_run && mul_done && mul_s) begin
            flags_nxt[FLAG_N] = mul_prod[WIDTH-1];
            flags_nxt[FLAG_Z] = (mul_prod == '0);
        end
    end

    // ---- stage p1: registered result, control state and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            wr_en_p1  <= 1'b0;
            flags_q   <= '0;
            mul_s     <= 1'b0;
        end else begin
            flags_q <= flags_nxt;
            if (vld_p1 && out_ready) vld_p1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state <= ST_MUL_RUN;
                        mul_s <= s_bit;
                    end else if (alu_acc) begin
                        vld_p1    <= 1'b1;
                        result_p1 <= alu_res;
                        wr_en_p1  <= !is_test;
                    end
                end
                ST_MUL_RUN: begin
                    if (mul_done) begin
                        if (vld_p1 && !out_ready) begin
                            state <= ST_HOLD;
                        end else begin
                            state     <= ST_IDLE;
                            vld_p1    <= 1'b1;
                            result_p1 <= mul_prod;
                            wr_en_p1  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!vld_p1 || out_ready) begin
                        state     <= ST_IDLE;
                        vld_p1    <= 1'b1;
                        result_p1 <= mul_prod;
                        wr_en_p1  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ---- multiply engine: one multiplier bit per cycle, WIDTH iterations
    generate
        if (MUL_EN != 0) begin : g_mul
            localparam logic [SHW:0] CNT_MAX = (SHW+1)'(WIDTH);

            logic [SHW:0]     cnt;
            logic [WIDTH-1:0] mcand;
            logic [WIDTH-1:0] mplier;
            logic [WIDTH-1:0] accum;

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt <= '0;
                end else if (mul_start) begin
                    cnt <= '0;
                end else if (mul_run && (cnt != CNT_MAX)) begin
                    cnt <= cnt + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (mul_start) begin
                    mcand  <= op_a;
                    mplier <= op_b;
                    accum  <= acc ? op_c : '0;
                end else if (mul_run && (cnt != CNT_MAX)) begin
                    if (mplier[0]) accum <= accum + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                end
            end

            assign mul_done = (cnt == CNT_MAX);
            assign mul_prod = accum;
        end else begin : g_no_mul
            assign mul_done = 1'b0;
            assign mul_prod = '0;
        end
    endgenerate

endmodule

// File: tb/tb_arm_dp_unit.sv
// Directed bench for arm_dp_unit (WIDTH=32): hand-computed vectors for the
// ALU, flag rules, shifter corner cases, MLA timing, reset abort and backpressure.
module tb_arm_dp_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic             s_bit;
    logic             mul;
    logic             acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_c;
    logic [1:0]       shift_type;
    logic [SHW-1:0]   shift_amt;
    logic             flags_load;
    logic [3:0]       flags_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             wr_en;
    logic [3:0]       flags;

    int n_total = 0;
    int n_bad   = 0;

    arm_dp_unit #(.WIDTH(WIDTH), .MUL_EN(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .s_bit      (s_bit),
        .mul        (mul),
        .acc        (acc),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_c       (op_c),
        .shift_type (shift_type),
        .shift_amt  (shift_amt),
        .flags_load (flags_load),
        .flags_in   (flags_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .wr_en      (wr_en),
        .flags      (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic [3:0] opc, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [1:0] st, input logic [4:0] amt);
        in_valid   = 1'b1;
        mul        = 1'b0;
        acc        = 1'b0;
        opcode     = opc;
        s_bit      = s;
        op_a       = a;
        op_b       = b;
        op_c       = '0;
        shift_type = st;
        shift_amt  = amt;
    endtask

    task automatic drive_mul(input logic accum, input logic s, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] c);
        in_valid   = 1'b1;
        mul        = 1'b1;
        acc        = accum;
        opcode     = 4'h0;
        s_bit      = s;
        op_a       = a;
        op_b       = b;
        op_c       = c;
        shift_type = 2'd0;
        shift_amt  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        int seen;
        int unstable;
        logic [31:0] held;

        reset = 1'b1; in_valid = 1'b0; opcode = '0; s_bit = 1'b0; mul = 1'b0; acc = 1'b0;
        op_a = '0; op_b = '0; op_c = '0; shift_type = '0; shift_amt = '0;
        flags_load = 1'b0; flags_in = '0; out_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        check("rst_vld", out_valid, 0);
        check("rst_flags", flags, 4'b0000);
        check("rst_rdy", in_ready, 1);
        check("rst_res", result, 0);

        // ADDS 0xFFFFFFFF + 1
        drive_alu(4'h4, 1, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd0);
        tick(); in_valid = 1'b0;
        check("adds_vld", out_valid, 1);
        check("adds_res", result, 32'h0);
        check("adds_wr", wr_en, 1);
        check("adds_flags", flags, 4'b0110);

        drive_alu(4'hA, 0, 32'd5, 32'd7, 2'd0, 5'd0);
        tick(); in_valid = 1'b0;
        check("cmp57_wr", wr_en, 0);
        check("cmp57_flags", flags, 4'b1000);
        drive_alu(4'hA, 0, 32'd7, 32'd5, 2'd0, 5'd0);
        tick(); in_valid = 1'b0;
        check("cmp75_flags", flags, 4'b0010);
        drive_alu(4'h2, 1, 32'h8000_0000, 32'h1, 2'd0, 5'd0);
        tick(); in_valid = 1'b0;
        check("subs_res", result, 32'h7FFF_FFFF);
        check("subs_flags", flags, 4'b0011);

        // Back-to-back ADDS then ADC using the fresh carry
        drive_alu(4'h4, 1, 32'hFFFF_FFFF, 32'h1, 2'd0, 5'd0);
        tick();
        check("b2b_rdy", in_ready, 1);
        drive_alu(4'h5, 0, 32'd2, 32'd3, 2'd0, 5'd0);
        tick(); in_valid = 1'b0;
        check("b2b_vld", out_valid, 1);
        check("b2b_adc", result, 32'd6);
        check("b2b_flags", flags, 4'b0110);
        tick();
        check("b2b_drain", out_valid, 0);

        // Shifter corners with C=1
        flags_load = 1'b1; flags_in = 4'b0010;
        tick(); flags_load = 1'b0;
        check("fload_idle", flags, 4'b0010);
        drive_alu(4'hD, 1, 32'h0, 32'h3, 2'd3, 5'd0);
        tick(); in_valid = 1'b0;
        check("rrx_res", result, 32'h8000_0001);
        check("rrx_flags", flags, 4'b1010);
        drive_alu(4'hD, 1, 32'h0, 32'h5, 2'd0, 5'd0);
        tick(); in_valid = 1'b0;
        check("lsl0_res", result, 32'h5);
        check("lsl0_flags", flags, 4'b0010);
        drive_alu(4'hD, 1, 32'h0, 32'h1, 2'd1, 5'd1);
        tick(); in_valid = 1'b0;
        check("lsr1_res", result, 32'h0);
        check("lsr1_flags", flags, 4'b0110);
        drive_alu(4'hD, 0, 32'h0, 32'h8000_0010, 2'd2, 5'd4);
        tick(); in_valid = 1'b0;
        check("asr4_res", result, 32'hF800_0001);

        // MLAS 0x10*0x20+5, MSR load mid-run
        drive_mul(1, 1, 32'h10, 32'h20, 32'h5);
        tick(); in_valid = 1'b0; mul = 1'b0;
        early = 0;
        for (int i = 1; i <= 32; i++) begin
            if (i == 5) begin flags_load = 1'b1; flags_in = 4'b1101; end
            if (i == 6) flags_load = 1'b0;
            tick();
            if (out_valid || in_ready) early++;
            if (i == 6) check("mul_fload", flags, 4'b1101);
        end
        check("mul_busy", early, 0);
        tick();
        check("mul_vld", out_valid, 1);
        check("mul_res", result, 32'h205);
        check("mul_wr", wr_en, 1);
        check("mul_flags", flags, 4'b0001);
        tick();

        // Reset in the middle of a multiply
        drive_mul(0, 1, 32'd3, 32'd4, 32'd0);
        tick(); in_valid = 1'b0; mul = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_noout", seen, 0);
        check("abort_flags", flags, 4'b0000);
        check("abort_rdy", in_ready, 1);

        // Backpressure: result held while a competing op is presented
        out_ready = 1'b0;
        drive_alu(4'h4, 0, 32'd10, 32'd20, 2'd0, 5'd0);
        tick();
        check("bp_vld", out_valid, 1);
        check("bp_res", result, 32'd30);
        held = result;
        drive_alu(4'hD, 0, 32'h0, 32'h77, 2'd0, 5'd0);
        unstable = 0;
        for (int i = 0; i < 4; i++) begin
            if (in_ready) unstable++;
            tick();
            if (!out_valid || result !== held || !wr_en) unstable++;
        end
        check("bp_stable", unstable, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release", out_valid, 0);

        // MSR load collides with ADDS: the op wins
        flags_load = 1'b1; flags_in = 4'b1111;
        drive_alu(4'h4, 1, 32'd1, 32'd1, 2'd0, 5'd0);
        tick(); in_valid = 1'b0; flags_load = 1'b0;
        check("coll_res", result, 32'd2);
        check("coll_flags", flags, 4'b0000);
        tick();
        check("coll_keep", flags, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/arm_dp_unit.md
# arm_dp_unit

Parametrised, registered successor to the combinational data-processing ALU: a WIDTH-bit ARM data-processing unit with built-in operand-2 barrel shifter, an internal NZCV flag register, a valid/ready handshake on both sides, and an optional iterative MUL/MLA engine. It sits in the execute stage between register read and writeback. Carry-in for ADC/SBC/RSC, RRX and zero-amount shifts comes from the stored C flag, not from a combinational loop.

## Interface
- WIDTH, 32: datapath width; power of two, >= 8.
- MUL_EN, 1: 1 instantiates the multiply engine; 0 ties it off, and `mul` is then ignored (treated as 0).
- SHW, $clog2(WIDTH): shift-amount width (derived; do not override).

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts this cycle.
- opcode  in  4  ARM DP opcode, 0x0 AND through 0xF MVN, standard encoding.
- s_bit  in  1  update flags.
- mul  in  1  multiply op (opcode ignored).
- acc  in  1  with mul: MLA (add op_c).
- op_a  in  WIDTH  Rn / Rm for multiply.
- op_b  in  WIDTH  operand-2 source / Rs for multiply.
- op_c  in  WIDTH  MLA accumuland.
- shift_type  in  2  0 LSL, 1 LSR, 2 ASR, 3 ROR.
- shift_amt  in  SHW  shift amount applied to op_b.
- flags_load  in  1  load flags_in into NZCV (MSR path).
- flags_in  in  4  {N,Z,C,V}.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- wr_en  out  1  result is to be written; 0 for TST/TEQ/CMP/CMN.
- flags  out  4  current NZCV register.

## Operation
- States: IDLE, MUL_RUN, HOLD. Reset → IDLE; out_valid=0, result=0, wr_en=0, flags=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept = in_valid && in_ready.
- Shifter (on op_b): LSL/LSR/ASR/ROR by shift_amt. For amt 0: LSL/LSR/ASR pass op_b unchanged with carry = stored C; ROR #0 = RRX ({C, op_b[WIDTH-1:1]}, carry = op_b[0]). For amt>0, carry = last bit shifted out.
- Arithmetic is done at WIDTH+1 bits.
  - C = carry out of add; for subtracts C = NOT borrow.
  - V = signed overflow of the actual add/sub, including carry-in.
  - Logical ops: C = shifter carry, V unchanged.
  - MOV/MVN operate on the shifted op_b.
- Flag write on accept of a non-mul op when s_bit=1 or opcode ∈ {TST,TEQ,CMP,CMN}: N = result MSB, Z = (result==0).
- MUL: product = op_a*op_b (+op_c if acc), low WIDTH bits.
  - Shift-add engine, one bit per cycle, WIDTH iterations in MUL_RUN.
  - MULS updates N and Z only; C and V are unchanged.
- flags_load in the same cycle as a flag-updating accept: the accepted op wins. flags_load while MUL_RUN is pending (multiply with S set): flags_load is applied now, and the multiply overwrites N and Z at completion.
- HOLD: result, wr_en and out_valid stay stable until out_ready. A completing multiply waits in HOLD if out_valid && !out_ready.
- Reset mid-multiply aborts it. Flags are cleared and nothing is emitted.

## Timing
- ALU op latency is 1: accept at edge k gives out_valid=1 after edge k. Flags are updated at the same edge k.
- Back-to-back ALU ops sustain 1 op/cycle while out_ready=1. ADC after ADDS uses the new C with no bubble.
- Multiply latency is WIDTH+1 edges from accept to out_valid. in_ready=0 throughout.
- out_valid falls at the edge where out_ready=1, unless a new accept occurs at that edge.

## Structure
- Package `arm_dp_pkg`:
  - opcode localparams (AND..MVN);
  - shift-type codes;
  - flag bit indices N=3, Z=2, C=1, V=0;
  - state enum.
- Sub-module `dp_barrel_shifter` (WIDTH param; inputs value, type, amt, c_in; outputs value and carry). It is combinational and instantiated once.
- The multiply engine stays inline, under a generate on MUL_EN.

## Test plan
- Reset: out_valid=0, flags=0000, in_ready=1. Then ADDS 0xFFFFFFFF+1 → result 0, wr_en=1, flags Z=1 C=1 N=0 V=0.
- CMP 5,7 → wr_en=0, flags N=1 C=0; CMP 7,5 → C=1. SUBS 0x80000000-1 → V=1.
- ADDS 0xFFFFFFFF+1 then ADC 2+3 back-to-back → 6; one result per cycle with out_ready=1.
- Shifter, with C=1:
  - MOV ROR #0 of 0x00000003 → 0x80000001, C=1.
  - MOVS LSL #0 leaves C=1.
  - LSRS #1 of 0x1 → 0, C=1.
- MLA 0x10*0x20+5, WIDTH=32 → 0x205; out_valid after 33 edges; in_ready=0 meanwhile. Reset asserted at cycle 10 → no output.
- Backpressure: out_ready=0 for 4 cycles → result stable, in_ready=0. Simultaneous flags_load=1111 and ADDS 1+1 → flags 0000.
